// File: rtl/uart_led_ctrl.sv
// 8N1 UART command receiver that reprograms the led_cnt blink divider via div_o/wren_o.
// Optional echo transmitter on tx_o is built only when UART_LED_ECHO_EN is defined.
module uart_led_ctrl #(
   parameter int         CLK_HZ   = 100_000_000,
   parameter int         BAUD     = 115200,
   parameter logic [7:0] HDR_BYTE = 8'hA5
) (
   input  logic       clk100,
   input  logic       rst,
   input  logic       rx_i,
   output logic       tx_o,
   output logic [4:0] div_o,
   output logic       wren_o,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o,
   output logic [7:0] err_cnt_o
);

   // CLKS_PER_BIT must be at least 16 so the half-bit start sample is meaningful.
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   localparam logic [2:0] R_IDLE  = 3'd0;
   localparam logic [2:0] R_START = 3'd1;
   localparam logic [2:0] R_DATA  = 3'd2;
   localparam logic [2:0] R_STOP  = 3'd3;
   localparam logic [2:0] R_BRK   = 3'd4;

   localparam logic P_HDR = 1'b0;
   localparam logic P_VAL = 1'b1;

   logic             rx_meta;
   logic             rx_s;
   logic [2:0]       rx_state;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_sh;
   logic             p_state;
   logic             stop_bad;
   logic             val_reject;

   // Line idles high, so the synchronizer resets to 1 to avoid a phantom start bit.
   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
      end
   end

   assign stop_bad = (rx_state == R_STOP) && (rx_cnt == CNT_LAST) && !rx_s;

   // R_BRK holds off after a bad stop bit until the line returns high, so a break counts once.
   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         rx_state     <= R_IDLE;
         rx_cnt       <= '0;
         rx_bit       <= '0;
         rx_sh        <= '0;
         byte_o       <= '0;
         byte_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         byte_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
         case (rx_state)
            R_IDLE: begin
               rx_cnt <= '0;
               if (!rx_s) rx_state <= R_START;
            end
            R_START: begin
               if (rx_cnt == CNT_HALF) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s ? R_IDLE : R_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            R_DATA: begin
               if (rx_cnt == CNT_LAST) begin
                  rx_cnt <= '0;
                  rx_sh  <= {rx_s, rx_sh[7:1]};
                  rx_bit <= rx_bit + 1'b1;
                  if (rx_bit == 3'd7) rx_state <= R_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            R_STOP: begin
               if (rx_cnt == CNT_LAST) begin
                  rx_cnt <= '0;
                  if (rx_s) begin
                     byte_o       <= rx_sh;
                     byte_valid_o <= 1'b1;
                     rx_state     <= R_IDLE;
                  end else begin
                     frame_err_o <= 1'b1;
                     rx_state    <= R_BRK;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            R_BRK: begin
               rx_cnt <= '0;
               if (rx_s) rx_state <= R_IDLE;
            end
            default: rx_state <= R_IDLE;
         endcase
      end
   end

   assign val_reject = byte_valid_o && (p_state == P_VAL) &&
                       (byte_o != HDR_BYTE) && (byte_o[7:5] != 3'b000);

   // Command parser: header byte, then a value byte whose top three bits must be clear.
   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         p_state <= P_HDR;
         div_o   <= 5'h14;
         wren_o  <= 1'b0;
      end else begin
         wren_o <= 1'b0;
         if (frame_err_o) begin
            p_state <= P_HDR;
         end else if (byte_valid_o) begin
            if (p_state == P_HDR) begin
               if (byte_o == HDR_BYTE) p_state <= P_VAL;
            end else if (byte_o == HDR_BYTE) begin
               p_state <= P_VAL;
            end else if (byte_o[7:5] == 3'b000) begin
               div_o   <= byte_o[4:0];
               wren_o  <= 1'b1;
               p_state <= P_HDR;
            end else begin
               p_state <= P_HDR;
            end
         end
      end
   end

   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         err_cnt_o <= '0;
      end else if ((stop_bad || val_reject) && (err_cnt_o != 8'hFF)) begin
         err_cnt_o <= err_cnt_o + 8'd1;
      end
   end

`ifdef UART_LED_ECHO_EN
   localparam logic [1:0] T_IDLE  = 2'd0;
   localparam logic [1:0] T_START = 2'd1;
   localparam logic [1:0] T_DATA  = 2'd2;
   localparam logic [1:0] T_STOP  = 2'd3;

   logic [1:0]       tx_state;
   logic [CNT_W-1:0] tx_cnt;
   logic [2:0]       tx_bit;
   logic [7:0]       tx_sh;

   // Bytes arriving while a previous echo is still on the wire are dropped.
   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         tx_state <= T_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         tx_o     <= 1'b1;
      end else begin
         case (tx_state)
            T_IDLE: begin
               tx_o   <= 1'b1;
               tx_cnt <= '0;
               if (byte_valid_o) begin
                  tx_sh    <= byte_o;
                  tx_o     <= 1'b0;
                  tx_state <= T_START;
               end
            end
            T_START: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx_o     <= tx_sh[0];
                  tx_state <= T_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            T_DATA: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_o     <= 1'b1;
                     tx_state <= T_STOP;
                  end else begin
                     tx_sh  <= {1'b0, tx_sh[7:1]};
                     tx_o   <= tx_sh[1];
                     tx_bit <= tx_bit + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            T_STOP: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= T_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= T_IDLE;
         endcase
      end
   end
`else
   assign tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_uart_led_ctrl.sv
// Self-checking bench for uart_led_ctrl: a frame-level model predicts strobes, div_o and err_cnt_o.
// Runs with 16 clocks per bit; echo checks are active when UART_LED_ECHO_EN is defined.
module tb_uart_led_ctrl;

   localparam int         CLK_HZ = 1_600_000;
   localparam int         BAUD   = 100_000;
   localparam int         CPB    = CLK_HZ / BAUD;
   localparam logic [7:0] HDR    = 8'hA5;

   logic       clk100 = 1'b0;
   logic       rst    = 1'b1;
   logic       rx_i   = 1'b1;
   logic       tx_o;
   logic [4:0] div_o;
   logic       wren_o;
   logic [7:0] byte_o;
   logic       byte_valid_o;
   logic       frame_err_o;
   logic [7:0] err_cnt_o;

   uart_led_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .HDR_BYTE(HDR)) dut (
      .clk100       (clk100),
      .rst          (rst),
      .rx_i         (rx_i),
      .tx_o         (tx_o),
      .div_o        (div_o),
      .wren_o       (wren_o),
      .byte_o       (byte_o),
      .byte_valid_o (byte_valid_o),
      .frame_err_o  (frame_err_o),
      .err_cnt_o    (err_cnt_o)
   );

   always #5 clk100 = ~clk100;

   typedef struct packed {
      logic       is_ferr;
      logic [7:0] data;
      logic       echo;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] tx_exp[$];
   logic [7:0] tx_got[$];

   int         pass_cnt  = 0;
   int         total_cnt = 0;

   logic [4:0] m_div   = 5'h14;
   logic [4:0] pend_div = 5'h00;
   logic [7:0] m_byte  = 8'h00;
   int         m_err   = 0;
   bit         p_val   = 1'b0;
   bit         exp_wren = 1'b0;

   task automatic checkVal(input string name, input int actual, input int expected);
      total_cnt++;
      if (actual == expected) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
   endtask

   task automatic incErr();
      if (m_err < 255) m_err++;
   endtask

   // Command-level model of the parser, fed with the bytes the bench intended to send.
   task automatic modelByte(input logic [7:0] b);
      if (!p_val) begin
         if (b == HDR) p_val = 1'b1;
      end else if (b == HDR) begin
         p_val = 1'b1;
      end else if (b < 8'h20) begin
         pend_div = b[4:0];
         exp_wren = 1'b1;
         p_val    = 1'b0;
      end else begin
         incErr();
         p_val = 1'b0;
      end
   endtask

   always @(negedge clk100) begin
      if (!rst) begin
         checkVal("wren_o", int'(wren_o), int'(exp_wren));
         if (exp_wren) m_div = pend_div;
         exp_wren = 1'b0;
         if (byte_valid_o) begin
            checkVal("byte_valid_o expected", int'(exp_q.size() != 0 && !exp_q[0].is_ferr), 1);
            if (exp_q.size() != 0 && !exp_q[0].is_ferr) begin
               checkVal("byte_o at strobe", int'(byte_o), int'(exp_q[0].data));
               m_byte = exp_q[0].data;
               if (exp_q[0].echo) tx_exp.push_back(exp_q[0].data);
               modelByte(exp_q[0].data);
               void'(exp_q.pop_front());
            end
         end
         if (frame_err_o) begin
            checkVal("frame_err_o expected", int'(exp_q.size() != 0 && exp_q[0].is_ferr), 1);
            if (exp_q.size() != 0 && exp_q[0].is_ferr) void'(exp_q.pop_front());
            incErr();
            p_val = 1'b0;
         end
         checkVal("div_o", int'(div_o), int'(m_div));
         checkVal("byte_o", int'(byte_o), int'(m_byte));
`ifndef UART_LED_ECHO_EN
         checkVal("tx_o idle", int'(tx_o), 1);
`endif
      end
   end

`ifdef UART_LED_ECHO_EN
   always begin
      logic [7:0] b;
      @(negedge clk100);
      while (tx_o !== 1'b0) @(negedge clk100);
      repeat (CPB / 2) @(negedge clk100);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk100);
         b[i] = tx_o;
      end
      repeat (CPB) @(negedge clk100);
      checkVal("tx stop bit", int'(tx_o), 1);
      tx_got.push_back(b);
   end
`endif

   task automatic driveBit(input logic v);
      rx_i = v;
      repeat (CPB) @(negedge clk100);
   endtask

   // One 8N1 frame; stop=0 makes a framing error, hold_low extends the low line afterwards.
   task automatic applyStimulus(input logic [7:0] b, input logic stop, input int hold_low,
                                input int gap_bits, input logic echo);
      ev_t e;
      e.is_ferr = !stop;
      e.data    = b;
      e.echo    = echo;
      exp_q.push_back(e);
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(b[i]);
      driveBit(stop);
      if (hold_low > 0) begin
         rx_i = 1'b0;
         repeat (hold_low) @(negedge clk100);
      end
      rx_i = 1'b1;
      repeat (gap_bits * CPB) @(negedge clk100);
   endtask

   task automatic checkOutput(input string name);
      repeat (12 * CPB) @(negedge clk100);
      checkVal({name, " events drained"}, exp_q.size(), 0);
      checkVal({name, " err_cnt_o"}, int'(err_cnt_o), m_err);
`ifdef UART_LED_ECHO_EN
      checkVal({name, " echo count"}, tx_got.size(), tx_exp.size());
      while (tx_got.size() != 0 && tx_exp.size() != 0) begin
         checkVal({name, " echo byte"}, int'(tx_got.pop_front()), int'(tx_exp.pop_front()));
      end
      tx_got.delete();
      tx_exp.delete();
`endif
   endtask

   task automatic doReset(input int cycles);
      @(negedge clk100);
      rst = 1'b1;
      exp_q.delete();
      m_div    = 5'h14;
      m_byte   = 8'h00;
      m_err    = 0;
      p_val    = 1'b0;
      exp_wren = 1'b0;
      repeat (cycles) @(negedge clk100);
      rx_i = 1'b1;
      repeat (2) @(negedge clk100);
      rst = 1'b0;
      @(negedge clk100);
   endtask

   task automatic checkResetValues(input string name);
      checkVal({name, " div_o"}, int'(div_o), 'h14);
      checkVal({name, " tx_o"}, int'(tx_o), 1);
      checkVal({name, " byte_o"}, int'(byte_o), 0);
      checkVal({name, " err_cnt_o"}, int'(err_cnt_o), 0);
      checkVal({name, " strobes"}, int'({byte_valid_o, frame_err_o, wren_o}), 0);
   endtask

   initial begin
      doReset(4);
      checkResetValues("reset");
      repeat (20 * CPB) @(negedge clk100);
      checkOutput("idle");

      applyStimulus(8'hA5, 1'b1, 0, 2, 1'b1);
      applyStimulus(8'h0A, 1'b1, 0, 2, 1'b1);
      checkOutput("A5 0A");
      checkVal("div after A5 0A", int'(div_o), 'h0A);

      applyStimulus(8'hA5, 1'b1, 0, 2, 1'b1);
      applyStimulus(8'h3F, 1'b1, 0, 2, 1'b1);
      checkOutput("A5 3F");
      checkVal("err after 3F", int'(err_cnt_o), 1);
      checkVal("div kept after 3F", int'(div_o), 'h0A);
      applyStimulus(8'hA5, 1'b1, 0, 2, 1'b1);
      applyStimulus(8'h05, 1'b1, 0, 2, 1'b1);
      checkOutput("A5 05");
      checkVal("div after A5 05", int'(div_o), 'h05);

      applyStimulus(8'h55, 1'b0, 0, 2, 1'b0);
      checkOutput("bad stop");
      checkVal("err after bad stop", int'(err_cnt_o), 2);
      applyStimulus(8'hA5, 1'b1, 0, 2, 1'b1);
      applyStimulus(8'h55, 1'b0, 0, 2, 1'b0);
      applyStimulus(8'h0A, 1'b1, 0, 2, 1'b1);
      checkOutput("ferr in P_VAL");
      checkVal("div kept after ferr", int'(div_o), 'h05);
      applyStimulus(8'h00, 1'b0, 5 * 10 * CPB, 2, 1'b0);
      checkOutput("break");
      checkVal("err after break", int'(err_cnt_o), 4);

      applyStimulus(8'hA5, 1'b1, 0, 0, 1'b1);
      applyStimulus(8'h1C, 1'b1, 0, 2, 1'b0);
      checkOutput("back-to-back");
      checkVal("div after back-to-back", int'(div_o), 'h1C);
      applyStimulus(8'hA5, 1'b1, 0, 2, 1'b1);
      applyStimulus(8'hA5, 1'b1, 0, 2, 1'b1);
      applyStimulus(8'h07, 1'b1, 0, 2, 1'b1);
      checkOutput("resync");
      checkVal("div after resync", int'(div_o), 'h07);

      rx_i = 1'b0;
      repeat ((CPB * 4) / 10) @(negedge clk100);
      rx_i = 1'b1;
      repeat (20 * CPB) @(negedge clk100);
      checkOutput("glitch");

      rx_i = 1'b0;
      repeat (CPB) @(negedge clk100);
      rx_i = 1'b0;
      repeat (CPB) @(negedge clk100);
      rx_i = 1'b1;
      repeat (CPB + CPB / 2) @(negedge clk100);
      doReset(3);
      checkResetValues("mid-frame reset");
      applyStimulus(8'hA5, 1'b1, 0, 2, 1'b1);
      applyStimulus(8'h12, 1'b1, 0, 2, 1'b1);
      checkOutput("after reset");
      checkVal("div after reset frame", int'(div_o), 'h12);

      for (int i = 0; i < 260; i++) applyStimulus(8'h00, 1'b0, 0, 1, 1'b0);
      checkOutput("saturation");
      checkVal("err saturated", int'(err_cnt_o), 'hFF);

      $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
